// File: rtl/tof_pkg.sv
// tof_pkg: types shared by the ToF BRAM read path.
// BRAM geometry, requester IDs, read FSM states, read-pipe tag.
package tof_pkg;

    localparam int BRAM_ADDR_W = 9;
    localparam int BRAM_DATA_W = 16;
    localparam int BRAM_LEN_W  = 10;

    localparam logic REQ_SURF  = 1'b0;
    localparam logic REQ_PLANE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_e;

    typedef struct packed {
        logic valid;
        logic owner;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/tof_bram_rd_arbiter_if.sv
// tof_bram_rd_arbiter_if: requester, BRAM port-B and status signals.
// master = the arbiter, slave = requesters plus BRAM.
interface tof_bram_rd_arbiter_if #(
    parameter int ADDR_W = tof_pkg::BRAM_ADDR_W,
    parameter int DATA_W = tof_pkg::BRAM_DATA_W,
    parameter int LEN_W  = tof_pkg::BRAM_LEN_W
);

    logic              wr_busy;
    logic              req_0;
    logic              req_1;
    logic [ADDR_W-1:0] req_addr_0;
    logic [ADDR_W-1:0] req_addr_1;
    logic [LEN_W-1:0]  req_len_0;
    logic [LEN_W-1:0]  req_len_1;
    logic              ack_0;
    logic              ack_1;
    logic              dvalid_0;
    logic              dvalid_1;
    logic              dlast_0;
    logic              dlast_1;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] bram_addrb;
    logic [DATA_W-1:0] bram_doutb;
    logic              busy;

    modport master (
        input  wr_busy,
        input  req_0,
        input  req_1,
        input  req_addr_0,
        input  req_addr_1,
        input  req_len_0,
        input  req_len_1,
        output ack_0,
        output ack_1,
        output dvalid_0,
        output dvalid_1,
        output dlast_0,
        output dlast_1,
        output rd_data,
        output bram_addrb,
        input  bram_doutb,
        output busy
    );

    modport slave (
        output wr_busy,
        output req_0,
        output req_1,
        output req_addr_0,
        output req_addr_1,
        output req_len_0,
        output req_len_1,
        input  ack_0,
        input  ack_1,
        input  dvalid_0,
        input  dvalid_1,
        input  dlast_0,
        input  dlast_1,
        input  rd_data,
        input  bram_addrb,
        output bram_doutb,
        input  busy
    );

endinterface

// File: rtl/tof_rd_pipe.sv
// tof_rd_pipe: RD_LAT-deep shift of {valid, owner, last} tags.
// Tags line up with BRAM read data at the output stage.
module tof_rd_pipe
    import tof_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out,
    output logic    in_flight
);

    rd_tag_t stg [RD_LAT];

    // shift tags one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign tag_out = stg[RD_LAT-1];

    // any valid tag still travelling, output stage included
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight | stg[i].valid;
        end
    end

endmodule

// File: rtl/tof_bram_rd_arbiter.sv
// tof_bram_rd_arbiter: round-robin burst arbiter for ToF BRAM port B.
// Serves the surface and plane-fit paths one whole burst at a time.
module tof_bram_rd_arbiter
    import tof_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W,
    parameter int LEN_W  = BRAM_LEN_W,
    parameter int RD_LAT = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    tof_bram_rd_arbiter_if.master bus
);

    rd_state_e         state;
    logic              rr_last;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining;
    logic              ack_0_q;
    logic              ack_1_q;
    logic              busy_q;
    rd_tag_t           iss_tag;
    rd_tag_t           pipe_out;
    logic              pipe_busy;

    logic              any_req;
    logic              gnt_id;
    logic [ADDR_W-1:0] gnt_addr;
    logic [LEN_W-1:0]  gnt_len;
    logic [DATA_W-1:0] rd_word;

    // pick the winner; a tie goes to the requester not served last
    always_comb begin
        any_req = bus.req_0 | bus.req_1;
        gnt_id  = REQ_SURF;
        unique case (1'b1)
            bus.req_0 && bus.req_1:
                gnt_id = (rr_last == REQ_SURF) ? REQ_PLANE : REQ_SURF;
            bus.req_1 && !bus.req_0:
                gnt_id = REQ_PLANE;
            default:
                gnt_id = REQ_SURF;
        endcase
        gnt_addr = (gnt_id == REQ_PLANE) ? bus.req_addr_1 : bus.req_addr_0;
        gnt_len  = (gnt_id == REQ_PLANE) ? bus.req_len_1 : bus.req_len_0;
    end

    // burst FSM: the grant edge issues beat 0, ISSUE the rest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_last   <= REQ_PLANE;
            cur_addr  <= '0;
            addr_q    <= '0;
            remaining <= '0;
            ack_0_q   <= 1'b0;
            ack_1_q   <= 1'b0;
            busy_q    <= 1'b0;
            iss_tag   <= '0;
        end else begin
            ack_0_q       <= 1'b0;
            ack_1_q       <= 1'b0;
            iss_tag.valid <= 1'b0;
            iss_tag.last  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!bus.wr_busy && any_req) begin
                        ack_0_q       <= (gnt_id == REQ_SURF);
                        ack_1_q       <= (gnt_id == REQ_PLANE);
                        busy_q        <= 1'b1;
                        rr_last       <= gnt_id;
                        iss_tag.owner <= gnt_id;
                        if (gnt_len == '0) begin
                            state <= DRAIN;
                        end else begin
                            addr_q        <= gnt_addr;
                            iss_tag.valid <= 1'b1;
                            iss_tag.last  <= (gnt_len == LEN_W'(1));
                            cur_addr      <= gnt_addr + ADDR_W'(1);
                            remaining     <= gnt_len - LEN_W'(1);
                            state <= (gnt_len == LEN_W'(1)) ? DRAIN : ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    addr_q        <= cur_addr;
                    iss_tag.valid <= 1'b1;
                    iss_tag.last  <= (remaining == LEN_W'(1));
                    cur_addr      <= cur_addr + ADDR_W'(1);
                    remaining     <= remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!iss_tag.valid && !pipe_busy) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tof_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_in    (iss_tag),
        .tag_out   (pipe_out),
        .in_flight (pipe_busy)
    );

    assign rd_word = bus.bram_doutb;

    assign bus.ack_0      = ack_0_q;
    assign bus.ack_1      = ack_1_q;
    assign bus.busy       = busy_q;
    assign bus.bram_addrb = addr_q;
    assign bus.rd_data    = rd_word;
    assign bus.dvalid_0   = pipe_out.valid && (pipe_out.owner == REQ_SURF);
    assign bus.dvalid_1   = pipe_out.valid && (pipe_out.owner == REQ_PLANE);
    assign bus.dlast_0    = pipe_out.valid && pipe_out.last
                            && (pipe_out.owner == REQ_SURF);
    assign bus.dlast_1    = pipe_out.valid && pipe_out.last
                            && (pipe_out.owner == REQ_PLANE);

endmodule

// File: tb/tb_tof_bram_rd_arbiter.sv
// tb_tof_bram_rd_arbiter: directed bench for the BRAM read arbiter.
// Burst table plus hand sequences for arbitration, hold-off and reset.
module tb_tof_bram_rd_arbiter;

    localparam int RD_LAT = 1;

    typedef struct {
        bit          id;
        logic [8:0]  addr;
        logic [9:0]  len;
        bit          wr_mid;
        int          exp_beats;
        logic [8:0]  exp_last_addr;
        int          exp_busy_clr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [15:0] mem [512];

    tof_bram_rd_arbiter_if bus ();

    tof_bram_rd_arbiter #(
        .ADDR_W (9),
        .DATA_W (16),
        .LEN_W  (10),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-cycle BRAM port-B read model
    always @(posedge clk) bus.bram_doutb <= mem[bus.bram_addrb];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.ack_0, bus.ack_1, bus.dvalid_0, bus.dvalid_1,
                bus.dlast_0, bus.dlast_1, bus.busy};
    endfunction

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 700 && !done; i++) begin
            @(posedge clk); #1;
            if (!bus.busy) done = 1;
        end
        check(name, done, 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   beats, data_err, addr_err, leak, seq_err;
        int   last_cnt, last_idx, busy_clr, ack_lat;
        logic [15:0] last_data;
        logic [8:0]  a;
        logic got, dv_x, dl_x, dv_o, dl_o, busy0, ack_o;
        logic [8:0] addr0;
        beats = 0; data_err = 0; addr_err = 0; leak = 0; seq_err = 0;
        last_cnt = 0; last_idx = -1; busy_clr = -1; ack_lat = -1;
        last_data = '0;
        got = 0; busy0 = 0; ack_o = 0; addr0 = '0;
        @(negedge clk);
        if (v.id) begin
            bus.req_1 = 1; bus.req_addr_1 = v.addr; bus.req_len_1 = v.len;
        end else begin
            bus.req_0 = 1; bus.req_addr_0 = v.addr; bus.req_len_0 = v.len;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            got = v.id ? bus.ack_1 : bus.ack_0;
            if (got) begin
                ack_lat = i;
                ack_o = v.id ? bus.ack_0 : bus.ack_1;
                busy0 = bus.busy;
                addr0 = bus.bram_addrb;
            end
        end
        bus.req_0 = 0;
        bus.req_1 = 0;
        check($sformatf("vec%0d_ack_lat", idx), ack_lat, 0);
        check($sformatf("vec%0d_ack_other", idx), ack_o, 0);
        check($sformatf("vec%0d_busy_set", idx), busy0, 1);
        if (v.len != 0) check($sformatf("vec%0d_addr0", idx), addr0, v.addr);
        for (int c = 1; c < int'(v.len) + 6; c++) begin
            @(posedge clk); #1;
            if (v.wr_mid && c == 3) bus.wr_busy = 1;
            dv_x = v.id ? bus.dvalid_1 : bus.dvalid_0;
            dl_x = v.id ? bus.dlast_1 : bus.dlast_0;
            dv_o = v.id ? bus.dvalid_0 : bus.dvalid_1;
            dl_o = v.id ? bus.dlast_0 : bus.dlast_1;
            if (c < int'(v.len)) begin
                a = v.addr + 9'(c);
                if (bus.bram_addrb !== a) addr_err++;
            end
            if (dv_x) begin
                if (c != RD_LAT + beats) seq_err++;
                a = v.addr + 9'(beats);
                if (bus.rd_data !== mem[a]) data_err++;
                if (dl_x) begin
                    last_cnt++;
                    last_idx = beats;
                    last_data = bus.rd_data;
                end
                beats++;
            end else if (dl_x) begin
                seq_err++;
            end
            if (dv_o || dl_o) leak++;
            if (busy_clr < 0 && !bus.busy) busy_clr = c;
        end
        bus.wr_busy = 0;
        check($sformatf("vec%0d_beats", idx), beats, v.exp_beats);
        check($sformatf("vec%0d_data_err", idx), data_err, 0);
        check($sformatf("vec%0d_addr_err", idx), addr_err, 0);
        check($sformatf("vec%0d_seq_err", idx), seq_err, 0);
        check($sformatf("vec%0d_leak", idx), leak, 0);
        check($sformatf("vec%0d_busy_clr", idx), busy_clr, v.exp_busy_clr);
        if (v.exp_beats > 0) begin
            check($sformatf("vec%0d_last_cnt", idx), last_cnt, 1);
            check($sformatf("vec%0d_last_idx", idx), last_idx,
                  v.exp_beats - 1);
            check($sformatf("vec%0d_last_data", idx), last_data,
                  mem[v.exp_last_addr]);
        end else begin
            check($sformatf("vec%0d_no_last", idx), last_cnt, 0);
        end
    endtask

    initial begin
        vec_t vecs [7];
        int   w [3];
        int   n, both, hold_cnt, beats, leak;
        bit   got;

        vecs[0] = '{0,   9'd0,  10'd64, 0,  64,  9'd63,  66};
        vecs[1] = '{1, 9'd508,   10'd8, 0,   8,   9'd3,  10};
        vecs[2] = '{0, 9'd100,  10'd16, 1,  16, 9'd115,  18};
        vecs[3] = '{1, 9'd300,   10'd0, 0,   0,   9'd0,   1};
        vecs[4] = '{1, 9'd511,   10'd1, 0,   1, 9'd511,   3};
        vecs[5] = '{0, 9'd256, 10'd512, 0, 512, 9'd255, 514};
        vecs[6] = '{1,   9'd5,   10'd3, 0,   3,   9'd7,   5};

        errors = 0;
        checks = 0;
        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 37 + 4660);

        rst_n = 0;
        bus.wr_busy = 0;
        bus.req_0 = 0; bus.req_1 = 0;
        bus.req_addr_0 = '0; bus.req_addr_1 = '0;
        bus.req_len_0 = '0; bus.req_len_1 = '0;

        repeat (3) @(negedge clk);
        check("rst_outs", outs(), 0);
        check("rst_addr", bus.bram_addrb, 0);
        rst_n = 1;
        @(posedge clk); #1;
        check("post_rst_outs", outs(), 0);

        // simultaneous requests; req_0 re-requests right after its ack
        @(negedge clk);
        bus.req_0 = 1; bus.req_addr_0 = 9'd16; bus.req_len_0 = 10'd8;
        bus.req_1 = 1; bus.req_addr_1 = 9'd32; bus.req_len_1 = 10'd8;
        w = '{9, 9, 9};
        n = 0;
        both = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(posedge clk); #1;
            if (bus.ack_0 && bus.ack_1) both++;
            if (bus.ack_0) begin
                w[n] = 0;
                n++;
                if (n == 3) bus.req_0 = 0;
            end else if (bus.ack_1) begin
                w[n] = 1;
                n++;
                bus.req_1 = 0;
            end
        end
        bus.req_0 = 0;
        bus.req_1 = 0;
        check("rr_grants", n, 3);
        check("rr_first", w[0], 0);
        check("rr_second", w[1], 1);
        check("rr_third", w[2], 0);
        check("rr_double_ack", both, 0);
        wait_idle("rr_idle");

        // wr_busy holds off a pending request
        @(negedge clk);
        bus.wr_busy = 1;
        bus.req_0 = 1; bus.req_addr_0 = 9'd40; bus.req_len_0 = 10'd4;
        hold_cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.ack_0 || bus.ack_1 || bus.busy) hold_cnt++;
        end
        check("wrbusy_hold", hold_cnt, 0);
        @(negedge clk);
        bus.wr_busy = 0;
        @(posedge clk); #1;
        check("wrbusy_release_ack", bus.ack_0, 1);
        bus.req_0 = 0;
        wait_idle("wrbusy_idle");

        // asynchronous reset at beat 10 of a 32-word burst
        @(negedge clk);
        bus.req_0 = 1; bus.req_addr_0 = 9'd200; bus.req_len_0 = 10'd32;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            got = bus.ack_0;
        end
        bus.req_0 = 0;
        check("midrst_ack", got, 1);
        beats = 0;
        for (int i = 0; i < 60 && beats < 11; i++) begin
            @(posedge clk); #1;
            if (bus.dvalid_0) beats++;
        end
        check("midrst_beats_before", beats, 11);
        #2;
        rst_n = 0;
        #1;
        check("midrst_outs", outs(), 0);
        check("midrst_addr", bus.bram_addrb, 0);
        leak = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (outs() != 0) leak++;
        end
        check("midrst_quiet", leak, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
            wait_idle($sformatf("vec%0d_idle", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d",
                 errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tof_bram_rd_arbiter.md
# tof_bram_rd_arbiter

- Shares the single read port (port B) of the ToF data BRAM, 512 x 16-bit, between two burst requesters: requester 0 is the spherical-surface path, requester 1 is the plane-fit path.
- Sits between the BRAM and both calculation pipelines, replacing direct address drive from the read FSM.
- Grants whole bursts round-robin, generates sequential read addresses, and returns BRAM data tagged with valid/last strobes for the owning requester.
- Holds off new grants while the sensor write path is busy.

## Interface
Parameters:
- ADDR_W, 9, BRAM address width (512 words)
- DATA_W, 16, BRAM data width (distance in mm)
- LEN_W, 10, burst length field width; legal lengths 0..512
- RD_LAT, 1, BRAM port-B read latency in cycles (1..3)

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- wr_busy  in  1  high while the BRAM write FSM is filling a frame; blocks new grants
- req_0, req_1  in  1 each  burst request; held until the matching ack
- req_addr_0, req_addr_1  in  ADDR_W each  burst start address
- req_len_0, req_len_1  in  LEN_W each  burst length in words
- ack_0, ack_1  out  1 each  one-cycle pulse; the request is accepted and its addr/len are latched
- dvalid_0, dvalid_1  out  1 each  rd_data is a valid beat for this requester
- dlast_0, dlast_1  out  1 each  marks the final beat of the burst, qualified by dvalid
- rd_data  out  DATA_W  shared read data, passed straight through from bram_doutb
- bram_addrb  out  ADDR_W  BRAM port-B address
- bram_doutb  in  DATA_W  BRAM port-B data
- busy  out  1  high from grant until the last beat has left the read pipe

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - Grants only when wr_busy=0 and at least one req is high.
  - If both requesters are waiting, the one not granted last wins. After reset, requester 0 wins the first tie.
  - On grant: latch addr and len, pulse ack, set busy, move to ISSUE.
- Zero-length bursts:
  - A request with len=0 is acked normally.
  - No beats are produced and no dlast is raised.
  - The FSM returns to IDLE on the next cycle.
- ISSUE:
  - Drives bram_addrb = cur_addr and pushes {valid, owner, last} into an RD_LAT-deep shift pipe.
  - Each cycle: cur_addr++ modulo 2^ADDR_W (511 wraps to 0), remaining--.
  - The beat issued with remaining==1 carries last=1. The FSM then moves to DRAIN.
- DRAIN:
  - Waits until the pipe is empty, then returns to IDLE and clears busy.
  - There is at least one IDLE cycle between bursts.
- Pipe output drives dvalid_x and dlast_x for owner x only. The other requester's strobes stay 0.
- wr_busy rising during ISSUE or DRAIN does not abort the burst. It only gates the next grant.
- A req that drops before its ack is treated as withdrawn. No state is kept for it.
- bram_addrb holds its last value outside ISSUE.

## Timing
- Reset values: ack_x=0, dvalid_x=0, dlast_x=0, busy=0, bram_addrb=0, state=IDLE, round-robin pointer = "last granted 1".
- rst_n is asynchronous. Asserting it mid-burst clears everything immediately: no further beats and no dlast.
- Grant timing:
  - req sampled at edge T in IDLE.
  - ack, busy and the first bram_addrb become visible after edge T.
- Data timing:
  - First dvalid is visible after edge T+RD_LAT.
  - Beat k (0-based) is valid after edge T+RD_LAT+k.
  - dlast falls on beat len-1.
- Throughput: one word per cycle inside a burst.
- Grant-to-grant spacing is at least len+RD_LAT+1 cycles.

## Structure
- Shared package tof_pkg holds:
  - BRAM_ADDR_W=9 and BRAM_DATA_W=16
  - requester IDs REQ_SURF=0 and REQ_PLANE=1
  - the state enum {IDLE, ISSUE, DRAIN}
- Sub-module tof_rd_pipe: parameterised RD_LAT shift register of {valid, owner, last} with an asynchronous active-low clear. Used once.

## Test plan
- After reset, req_0 with addr=0, len=64 and RD_LAT=1 -> ack_0 after edge 1. dvalid_0 runs for 64 consecutive cycles with rd_data = BRAM[0..63]. dlast_0 is on the 64th beat. dvalid_1 stays 0 throughout.
- req_0 and req_1 asserted in the same cycle, both len=8 -> requester 0 served first, then requester 1. On a second simultaneous request, requester 1 is served first.
- Wrap-around: req_1 with addr=508, len=8 -> bram_addrb sequence 508,509,510,511,0,1,2,3. dlast_1 falls on address 3's data.
- wr_busy=1 with req_0 pending for 20 cycles -> no ack. When wr_busy drops, ack_0 follows after the next edge. Raising wr_busy mid-burst does not truncate the burst.
- len=0 on req_1 -> ack_1 pulses, no dvalid_1 and no dlast_1. busy clears within 2 cycles.
- rst_n asserted at beat 10 of a len=32 burst -> all outputs 0 immediately. After rst_n is released, a new req_0 is served normally.
